dma_mem_responder: RTL and testbench
====================================

// Module: dma_mem_responder
// PURPOSE
//  Memory-backed responder for the DMA command/data streams; it sits where the XDMA engine sits.
//  Accepts read and write commands (axis_mem_cmd) and sinks write data into on-chip RAM.
//  Returns read data from the same RAM. Used for PCIe-free simulation and loopback of DMA users.
// PARAMETERS
//  DEPTH    1024  RAM depth in 512-bit words (power of 2); word addr = address[6 +: $clog2(DEPTH)]
//  MAX_LEN  65536 max command length in bytes; longer commands are clamped and counted as errors
// PORTS
//  user_clk               in   1    sole clock
//  user_reset             in   1    synchronous, active-high reset
//  s_rd_cmd_valid/ready   in/out 1  read command handshake
//  s_rd_cmd_address       in   64   byte address (low 6 bits ignored)
//  s_rd_cmd_length        in   32   byte length
//  s_wr_cmd_valid/ready   in/out 1  write command handshake
//  s_wr_cmd_address       in   64   byte address (low 6 bits ignored)
//  s_wr_cmd_length        in   32   byte length
//  m_rd_data_valid/ready  out/in 1  read data stream handshake
//  m_rd_data_data/keep    out  512/64  read beat, byte enables
//  m_rd_data_last         out  1    last beat of command
//  s_wr_data_valid/ready  in/out 1  write data stream handshake
//  s_wr_data_data/keep    in   512/64  write beat, byte enables (masked write)
//  s_wr_data_last         in   1    last beat marker
//  rd_cmd_cnt, wr_cmd_cnt out  32   accepted command counters
//  err_cnt                out  32   protocol error counter
// BEHAVIOUR
//  Reset: all valid/ready=0, FSMs IDLE, counters 0; RAM contents retained; mid-burst reset aborts the burst silently
//  Beats = (length+63)>>6. length==0: accepted, no data, err_cnt+1. length>MAX_LEN: clamped, err_cnt+1
//  Read and write FSMs are independent. Each cmd_ready=1 only in IDLE
//  Write FSM IDLE->WR_DATA on cmd accept. s_wr_data_ready=1 only in WR_DATA
//   - each beat writes RAM[waddr] with keep mask; waddr+1 mod DEPTH (wrap-around)
//   - early last (beat<N): burst ends, err_cnt+1. Beat N without last: burst ends, err_cnt+1
//   - WR_DATA->IDLE after beat N; a new cmd is acceptable the next cycle
//  Read FSM IDLE->RD_STREAM on cmd accept. Synchronous RAM read, 1 cycle, feeding dma_resp_skid (2 entries)
//   - RAM read issued only when the skid has space for in-flight data; no beat loss or duplication under ready toggling
//   - first valid 2 cycles after cmd accept. With ready held high: 1 beat/cycle sustained
//   - keep all-ones except on the last beat: lower (length[5:0]==0 ? 64 : length[5:0]) bits set
//   - last=1 on beat N only; RD_STREAM->IDLE after beat N is issued to RAM
//  Same-cycle read and write of the same word: read returns old data (read-first)
//  Counters wrap at 2^32; err_cnt increments at most once per cycle even with simultaneous rd and wr errors
// CONFIGURATION
//  DMA_RESP_PATTERN_EN defined: read data ignores RAM; every 32-bit lane = beat index within the command (0..N-1);
//   writes still update RAM
//  Undefined: read data comes from RAM
// STRUCTURE
//  dma_resp_pkg: DATA_W=512, KEEP_W=64, BEAT_SHIFT=6, rd_state_t{IDLE,RD_STREAM}, wr_state_t{IDLE,WR_DATA}
//  Sub-module dma_resp_skid: 2-entry valid/ready buffer with a space-available output to the read FSM
// TESTING
//  1 wr cmd addr 0x0 len 256, 4 beats data=i, last on beat 3 -> RAM[0..3]=0..3, wr_cmd_cnt=1, err_cnt=0
//  2 rd cmd addr 0x0 len 256, ready=1 -> 4 beats data 0..3 on consecutive cycles, last on beat 3, keep all-ones
//  3 rd len 100, random ready toggling -> 2 beats, beat1 keep=64'h0000_000F_FFFF_FFFF, no loss or duplicates
//  4 wr addr (DEPTH-1)*64 len 128 -> words DEPTH-1 and 0 written (wrap); readback matches
//  5 wr len 192 with last on beat 1 -> err_cnt=1, wr FSM IDLE, next wr cmd accepted
//  6 reset mid-read after 2 of 8 beats -> valid=0 the next cycle, counters 0; a new rd cmd is served correctly
//  7 DMA_RESP_PATTERN_EN defined, rd len 512 -> beat k has data[479:448]=k for k=0..7

Source files
------------

// File: rtl/dma_resp_pkg.sv
// Shared constants, FSM state types and beat record for the DMA memory responder.
package dma_resp_pkg;
    localparam int unsigned DATA_W     = 512;
    localparam int unsigned KEEP_W     = 64;
    localparam int unsigned BEAT_SHIFT = 6;

    localparam logic [BEAT_SHIFT:0] BEAT_BYTES = {1'b1, {BEAT_SHIFT{1'b0}}};

    typedef enum logic {RdIdle, RdStream} rd_state_t;
    typedef enum logic {WrIdle, WrData} wr_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    // Byte enables for a final beat carrying nbytes (1..64) valid bytes.
    function automatic logic [KEEP_W-1:0] keep_mask(input logic [BEAT_SHIFT:0] nbytes);
        logic [KEEP_W-1:0] m;
        for (int i = 0; i < KEEP_W; i++) m[i] = (i < int'(nbytes));
        return m;
    endfunction
endpackage

// File: rtl/dma_resp_skid.sv
// Two-entry fall-through buffer between the RAM read port and the read data stream.
module dma_resp_skid
    import dma_resp_pkg::*;
(
    input  logic  user_clk,
    input  logic  user_reset,
    input  logic  in_valid,
    input  beat_t in_beat,
    output logic  space,
    output logic  out_valid,
    input  logic  out_ready,
    output beat_t out_beat
);
    beat_t      entry_q [2];
    logic       head_q, tail_q;
    logic [1:0] count_q;
    logic       push, pop;

    assign out_valid = (count_q != 2'd0) || in_valid;
    assign out_beat  = (count_q != 2'd0) ? entry_q[head_q] : in_beat;
    // An arriving beat skips storage only when the buffer is empty and it leaves at once.
    assign push  = in_valid && !((count_q == 2'd0) && out_ready);
    assign pop   = (count_q != 2'd0) && out_ready;
    // Room for one more beat even if nothing drains before it lands.
    assign space = (count_q == 2'd0) || ((count_q == 2'd1) && !in_valid);

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) tail_q <= ~tail_q;
            if (pop) head_q <= ~head_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge user_clk) begin
        if (push) entry_q[tail_q] <= in_beat;
    end
endmodule

// File: rtl/dma_mem_responder.sv
// RAM-backed stand-in for the XDMA command/data streams (simulation and loopback).
// Define DMA_RESP_PATTERN_EN to return beat-index patterns on reads instead of RAM data.
module dma_mem_responder
    import dma_resp_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned MAX_LEN = 65536
) (
    input  logic              user_clk,
    input  logic              user_reset,
    input  logic              s_rd_cmd_valid,
    output logic              s_rd_cmd_ready,
    input  logic [63:0]       s_rd_cmd_address,
    input  logic [31:0]       s_rd_cmd_length,
    input  logic              s_wr_cmd_valid,
    output logic              s_wr_cmd_ready,
    input  logic [63:0]       s_wr_cmd_address,
    input  logic [31:0]       s_wr_cmd_length,
    output logic              m_rd_data_valid,
    input  logic              m_rd_data_ready,
    output logic [DATA_W-1:0] m_rd_data_data,
    output logic [KEEP_W-1:0] m_rd_data_keep,
    output logic              m_rd_data_last,
    input  logic              s_wr_data_valid,
    output logic              s_wr_data_ready,
    input  logic [DATA_W-1:0] s_wr_data_data,
    input  logic [KEEP_W-1:0] s_wr_data_keep,
    input  logic              s_wr_data_last,
    output logic [31:0]       rd_cmd_cnt,
    output logic [31:0]       wr_cmd_cnt,
    output logic [31:0]       err_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    wr_state_t           wr_state_q, wr_state_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic [31:0]         wr_beats_q, wr_beats_d, wr_idx_q, wr_idx_d, wr_len;
    logic                wr_en, wr_err;
    rd_state_t           rd_state_q, rd_state_d;
    logic [AW-1:0]       raddr_q, raddr_d;
    logic [31:0]         rd_beats_q, rd_beats_d, rd_idx_q, rd_idx_d, rd_len;
    logic [BEAT_SHIFT:0] rd_tail_q, rd_tail_d;
    logic                rd_issue, rd_issue_last, rd_err;
    logic                rd_pend_q, rd_last_q;
    logic [KEEP_W-1:0]   rd_keep_q;
    logic [DATA_W-1:0]   rd_data;
    logic                skid_space;
    beat_t               skid_in, skid_out;
    logic                unused_addr;

    function automatic logic [31:0] clamp_len(input logic [31:0] len);
        return (len > 32'(MAX_LEN)) ? 32'(MAX_LEN) : len;
    endfunction

    assign wr_len        = clamp_len(s_wr_cmd_length);
    assign rd_len        = clamp_len(s_rd_cmd_length);
    assign rd_issue_last = (rd_idx_q == rd_beats_q - 32'd1);
    assign unused_addr   = ^{s_rd_cmd_address[BEAT_SHIFT-1:0], s_rd_cmd_address[63:BEAT_SHIFT+AW],
                             s_wr_cmd_address[BEAT_SHIFT-1:0], s_wr_cmd_address[63:BEAT_SHIFT+AW]};

    always_comb begin
        wr_state_d      = wr_state_q;
        waddr_d         = waddr_q;
        wr_beats_d      = wr_beats_q;
        wr_idx_d        = wr_idx_q;
        wr_en           = 1'b0;
        wr_err          = 1'b0;
        s_wr_cmd_ready  = (wr_state_q == WrIdle) && !user_reset;
        s_wr_data_ready = (wr_state_q == WrData) && !user_reset;
        unique case (wr_state_q)
            WrIdle: if (s_wr_cmd_valid && s_wr_cmd_ready) begin
                if (s_wr_cmd_length == 32'd0) begin
                    wr_err = 1'b1;
                end else begin
                    wr_err     = (s_wr_cmd_length > 32'(MAX_LEN));
                    wr_beats_d = (wr_len + 32'd63) >> BEAT_SHIFT;
                    waddr_d    = s_wr_cmd_address[BEAT_SHIFT +: AW];
                    wr_idx_d   = 32'd0;
                    wr_state_d = WrData;
                end
            end
            WrData: if (s_wr_data_valid && s_wr_data_ready) begin
                wr_en    = 1'b1;
                waddr_d  = waddr_q + AW'(1);
                wr_idx_d = wr_idx_q + 32'd1;
                if (wr_idx_q == wr_beats_q - 32'd1) begin
                    wr_state_d = WrIdle;
                    wr_err     = !s_wr_data_last;
                end else if (s_wr_data_last) begin
                    wr_state_d = WrIdle;
                    wr_err     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_state_d     = rd_state_q;
        raddr_d        = raddr_q;
        rd_beats_d     = rd_beats_q;
        rd_idx_d       = rd_idx_q;
        rd_tail_d      = rd_tail_q;
        rd_issue       = 1'b0;
        rd_err         = 1'b0;
        s_rd_cmd_ready = (rd_state_q == RdIdle) && !user_reset;
        unique case (rd_state_q)
            RdIdle: if (s_rd_cmd_valid && s_rd_cmd_ready) begin
                if (s_rd_cmd_length == 32'd0) begin
                    rd_err = 1'b1;
                end else begin
                    rd_err     = (s_rd_cmd_length > 32'(MAX_LEN));
                    rd_beats_d = (rd_len + 32'd63) >> BEAT_SHIFT;
                    raddr_d    = s_rd_cmd_address[BEAT_SHIFT +: AW];
                    rd_idx_d   = 32'd0;
                    rd_tail_d  = (rd_len[BEAT_SHIFT-1:0] == '0) ? BEAT_BYTES
                                                                 : {1'b0, rd_len[BEAT_SHIFT-1:0]};
                    rd_state_d = RdStream;
                end
            end
            RdStream: if (skid_space && !user_reset) begin
                rd_issue = 1'b1;
                raddr_d  = raddr_q + AW'(1);
                rd_idx_d = rd_idx_q + 32'd1;
                if (rd_issue_last) rd_state_d = RdIdle;
            end
            default: ;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            wr_state_q <= WrIdle;
            waddr_q    <= '0;
            wr_beats_q <= '0;
            wr_idx_q   <= '0;
            rd_state_q <= RdIdle;
            raddr_q    <= '0;
            rd_beats_q <= '0;
            rd_idx_q   <= '0;
            rd_tail_q  <= '0;
            rd_pend_q  <= 1'b0;
            rd_cmd_cnt <= '0;
            wr_cmd_cnt <= '0;
            err_cnt    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            waddr_q    <= waddr_d;
            wr_beats_q <= wr_beats_d;
            wr_idx_q   <= wr_idx_d;
            rd_state_q <= rd_state_d;
            raddr_q    <= raddr_d;
            rd_beats_q <= rd_beats_d;
            rd_idx_q   <= rd_idx_d;
            rd_tail_q  <= rd_tail_d;
            rd_pend_q  <= rd_issue;
            rd_cmd_cnt <= rd_cmd_cnt + 32'(s_rd_cmd_valid && s_rd_cmd_ready);
            wr_cmd_cnt <= wr_cmd_cnt + 32'(s_wr_cmd_valid && s_wr_cmd_ready);
            if (rd_err || wr_err) err_cnt <= err_cnt + 32'd1;
        end
    end

    always_ff @(posedge user_clk) begin
        if (wr_en) begin
            for (int b = 0; b < KEEP_W; b++) begin
                if (s_wr_data_keep[b]) mem[waddr_q][b*8 +: 8] <= s_wr_data_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge user_clk) begin
        if (rd_issue) begin
            rd_keep_q <= rd_issue_last ? keep_mask(rd_tail_q) : '1;
            rd_last_q <= rd_issue_last;
        end
    end

`ifdef DMA_RESP_PATTERN_EN
    logic [31:0] rd_pidx_q;
    always_ff @(posedge user_clk) begin
        if (rd_issue) rd_pidx_q <= rd_idx_q;
    end
    assign rd_data = {(DATA_W/32){rd_pidx_q}};
`else
    logic [DATA_W-1:0] rd_ram_q;
    // Same-cycle write to this word lands after the read, so the old data is returned.
    always_ff @(posedge user_clk) begin
        if (rd_issue) rd_ram_q <= mem[raddr_q];
    end
    assign rd_data = rd_ram_q;
`endif

    assign skid_in.data = rd_data;
    assign skid_in.keep = rd_keep_q;
    assign skid_in.last = rd_last_q;

    dma_resp_skid u_skid (
        .user_clk   (user_clk),
        .user_reset (user_reset),
        .in_valid   (rd_pend_q),
        .in_beat    (skid_in),
        .space      (skid_space),
        .out_valid  (m_rd_data_valid),
        .out_ready  (m_rd_data_ready),
        .out_beat   (skid_out)
    );

    assign m_rd_data_data = skid_out.data;
    assign m_rd_data_keep = skid_out.keep;
    assign m_rd_data_last = skid_out.last;
endmodule

// File: tb/tb_dma_mem_responder.sv
// Directed bench for dma_mem_responder: writes, reads, tails, wrap, errors, mid-burst reset.
// Build with DMA_RESP_PATTERN_EN defined to check the beat-index read pattern instead.
module tb_dma_mem_responder;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned MAX_LEN = 1024;

    logic         user_clk = 1'b0;
    logic         user_reset;
    logic         s_rd_cmd_valid, s_rd_cmd_ready;
    logic [63:0]  s_rd_cmd_address;
    logic [31:0]  s_rd_cmd_length;
    logic         s_wr_cmd_valid, s_wr_cmd_ready;
    logic [63:0]  s_wr_cmd_address;
    logic [31:0]  s_wr_cmd_length;
    logic         m_rd_data_valid, m_rd_data_ready, m_rd_data_last;
    logic [511:0] m_rd_data_data;
    logic [63:0]  m_rd_data_keep;
    logic         s_wr_data_valid, s_wr_data_ready, s_wr_data_last;
    logic [511:0] s_wr_data_data;
    logic [63:0]  s_wr_data_keep;
    logic [31:0]  rd_cmd_cnt, wr_cmd_cnt, err_cnt;

    int compared   = 0;
    int mismatched = 0;

    logic [511:0] cap_data [32];
    logic [63:0]  cap_keep [32];
    logic         cap_last [32];
    int           cap_cyc  [32];
    int           cap_n, cap_extra;
    logic         rd_v_after_cmd;

    always #5 user_clk = ~user_clk;

    dma_mem_responder #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
        .user_clk         (user_clk),
        .user_reset       (user_reset),
        .s_rd_cmd_valid   (s_rd_cmd_valid),
        .s_rd_cmd_ready   (s_rd_cmd_ready),
        .s_rd_cmd_address (s_rd_cmd_address),
        .s_rd_cmd_length  (s_rd_cmd_length),
        .s_wr_cmd_valid   (s_wr_cmd_valid),
        .s_wr_cmd_ready   (s_wr_cmd_ready),
        .s_wr_cmd_address (s_wr_cmd_address),
        .s_wr_cmd_length  (s_wr_cmd_length),
        .m_rd_data_valid  (m_rd_data_valid),
        .m_rd_data_ready  (m_rd_data_ready),
        .m_rd_data_data   (m_rd_data_data),
        .m_rd_data_keep   (m_rd_data_keep),
        .m_rd_data_last   (m_rd_data_last),
        .s_wr_data_valid  (s_wr_data_valid),
        .s_wr_data_ready  (s_wr_data_ready),
        .s_wr_data_data   (s_wr_data_data),
        .s_wr_data_keep   (s_wr_data_keep),
        .s_wr_data_last   (s_wr_data_last),
        .rd_cmd_cnt       (rd_cmd_cnt),
        .wr_cmd_cnt       (wr_cmd_cnt),
        .err_cnt          (err_cnt)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic rd_cmd(input logic [63:0] a, input logic [31:0] l);
        int n;
        n = 0;
        @(negedge user_clk);
        s_rd_cmd_valid = 1'b1; s_rd_cmd_address = a; s_rd_cmd_length = l;
        while (!s_rd_cmd_ready && n < 100) begin @(negedge user_clk); n++; end
        compared++;
        if (!s_rd_cmd_ready) begin
            mismatched++; $display("FAIL rd_cmd_accept: ready=0 after %0d cycles, required 1", n);
        end
        @(negedge user_clk);
        s_rd_cmd_valid = 1'b0;
        rd_v_after_cmd = m_rd_data_valid;
    endtask

    task automatic wr_cmd(input logic [63:0] a, input logic [31:0] l);
        int n;
        n = 0;
        @(negedge user_clk);
        s_wr_cmd_valid = 1'b1; s_wr_cmd_address = a; s_wr_cmd_length = l;
        while (!s_wr_cmd_ready && n < 100) begin @(negedge user_clk); n++; end
        compared++;
        if (!s_wr_cmd_ready) begin
            mismatched++; $display("FAIL wr_cmd_accept: ready=0 after %0d cycles, required 1", n);
        end
        @(negedge user_clk);
        s_wr_cmd_valid = 1'b0;
    endtask

    // Beat i carries base+i; last is raised on beat last_at (use -1 for never).
    task automatic wr_beats(input int n, input int last_at, input int base);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            @(negedge user_clk);
            s_wr_data_valid = 1'b1; s_wr_data_data = 512'(base + i);
            s_wr_data_keep = '1; s_wr_data_last = (i == last_at);
            while (!s_wr_data_ready && w < 100) begin @(negedge user_clk); w++; end
            compared++;
            if (!s_wr_data_ready) begin
                mismatched++; $display("FAIL wr_data_ready: beat %0d ready=0, required 1", i);
            end
        end
        @(negedge user_clk);
        s_wr_data_valid = 1'b0; s_wr_data_last = 1'b0;
    endtask

    // Collect n read beats, then watch extra cycles with ready high for unexpected beats.
    task automatic capture(input int n, input bit toggle, input int extra);
        int cyc;
        cyc = 0; cap_n = 0; cap_extra = 0;
        while (cap_n < n && cyc < 300) begin
            @(negedge user_clk);
            m_rd_data_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_rd_data_valid && m_rd_data_ready) begin
                cap_data[cap_n] = m_rd_data_data; cap_keep[cap_n] = m_rd_data_keep;
                cap_last[cap_n] = m_rd_data_last; cap_cyc[cap_n] = cyc;
                cap_n++;
            end
            cyc++;
        end
        for (int i = 0; i < extra; i++) begin
            @(negedge user_clk);
            m_rd_data_ready = 1'b1;
            if (m_rd_data_valid) cap_extra++;
        end
    endtask

    task automatic test_reset();
        user_reset = 1'b1;
        repeat (3) @(negedge user_clk);
        compared++;
        if (s_rd_cmd_ready !== 1'b0 || s_wr_cmd_ready !== 1'b0 || s_wr_data_ready !== 1'b0 ||
            m_rd_data_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_handshakes: rc=%b wc=%b wd=%b rv=%b, required all 0",
                     s_rd_cmd_ready, s_wr_cmd_ready, s_wr_data_ready, m_rd_data_valid);
        end
        compared++;
        if (rd_cmd_cnt !== 32'd0 || wr_cmd_cnt !== 32'd0 || err_cnt !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_counters: rd=%0d wr=%0d err=%0d, required 0 0 0",
                     rd_cmd_cnt, wr_cmd_cnt, err_cnt);
        end
        user_reset = 1'b0;
        @(negedge user_clk);
        compared++;
        if (s_rd_cmd_ready !== 1'b1 || s_wr_cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL idle_cmd_ready: rc=%b wc=%b, required 1 1", s_rd_cmd_ready, s_wr_cmd_ready);
        end
    endtask

`ifdef DMA_RESP_PATTERN_EN
    task automatic test_pattern();
        rd_cmd(64'h0, 32'd512);
        capture(8, 1'b0, 3);
        compared++;
        if (cap_n != 8 || cap_extra != 0) begin
            mismatched++; $display("FAIL pattern_count: got %0d+%0d beats, required 8+0", cap_n, cap_extra);
        end
        for (int k = 0; k < cap_n; k++) begin
            compared++;
            if (cap_data[k][479:448] !== 32'(k) || cap_data[k][31:0] !== 32'(k) ||
                cap_last[k] !== (k == 7)) begin
                mismatched++;
                $display("FAIL pattern_beat%0d: lane14=%0h lane0=%0h last=%b, required %0h %0h %b",
                         k, cap_data[k][479:448], cap_data[k][31:0], cap_last[k], k, k, k == 7);
            end
        end
    endtask
`else
    task automatic test_write();
        wr_cmd(64'h0, 32'd256);
        wr_beats(4, 3, 0);
        compared++;
        if (wr_cmd_cnt !== 32'd1 || err_cnt !== 32'd0 || s_wr_cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL write_basic: wr_cnt=%0d err=%0d cmd_ready=%b, required 1 0 1",
                     wr_cmd_cnt, err_cnt, s_wr_cmd_ready);
        end
    endtask

    task automatic test_read();
        rd_cmd(64'h0, 32'd256);
        capture(4, 1'b0, 4);
        compared++;
        if (rd_v_after_cmd !== 1'b0 || cap_n != 4 || cap_cyc[0] != 0) begin
            mismatched++;
            $display("FAIL read_latency: early_valid=%b beats=%0d first_cyc=%0d, required 0 4 0",
                     rd_v_after_cmd, cap_n, cap_cyc[0]);
        end
        for (int k = 0; k < cap_n; k++) begin
            compared++;
            if (cap_data[k] !== 512'(k) || cap_keep[k] !== '1 || cap_last[k] !== (k == 3) ||
                cap_cyc[k] != k) begin
                mismatched++;
                $display("FAIL read_beat%0d: data=%0h keep=%h last=%b cyc=%0d, required %0h all-ones %b %0d",
                         k, cap_data[k], cap_keep[k], cap_last[k], cap_cyc[k], k, k == 3, k);
            end
        end
        compared++;
        if (cap_extra != 0 || rd_cmd_cnt !== 32'd1) begin
            mismatched++;
            $display("FAIL read_tail: extra=%0d rd_cnt=%0d, required 0 1", cap_extra, rd_cmd_cnt);
        end
    endtask

    task automatic test_read_partial();
        rd_cmd(64'h0, 32'd100);
        capture(2, 1'b1, 4);
        compared++;
        if (cap_n != 2 || cap_extra != 0) begin
            mismatched++; $display("FAIL partial_count: got %0d+%0d beats, required 2+0", cap_n, cap_extra);
        end
        compared++;
        if (cap_data[0] !== 512'd0 || cap_keep[0] !== '1 || cap_last[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL partial_beat0: data=%0h keep=%h last=%b, required 0 all-ones 0",
                     cap_data[0], cap_keep[0], cap_last[0]);
        end
        compared++;
        if (cap_data[1] !== 512'd1 || cap_keep[1] !== 64'h0000_000F_FFFF_FFFF ||
            cap_last[1] !== 1'b1) begin
            mismatched++;
            $display("FAIL partial_beat1: data=%0h keep=%h last=%b, required 1 0000000fffffffff 1",
                     cap_data[1], cap_keep[1], cap_last[1]);
        end
    endtask

    task automatic test_wrap();
        wr_cmd(64'((DEPTH - 1) * 64), 32'd128);
        wr_beats(2, 1, 'hA0);
        rd_cmd(64'((DEPTH - 1) * 64), 32'd128);
        capture(2, 1'b0, 3);
        compared++;
        if (cap_n != 2 || cap_data[0] !== 512'hA0 || cap_data[1] !== 512'hA1 || cap_extra != 0) begin
            mismatched++;
            $display("FAIL wrap_readback: n=%0d d0=%0h d1=%0h extra=%0d, required 2 a0 a1 0",
                     cap_n, cap_data[0], cap_data[1], cap_extra);
        end
        rd_cmd(64'h0, 32'd64);
        capture(1, 1'b0, 3);
        compared++;
        if (cap_n != 1 || cap_data[0] !== 512'hA1 || cap_keep[0] !== '1 || cap_last[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL wrap_word0: n=%0d data=%0h keep=%h last=%b, required 1 a1 all-ones 1",
                     cap_n, cap_data[0], cap_keep[0], cap_last[0]);
        end
    endtask

    task automatic test_wr_errors();
        wr_cmd(64'h100, 32'd192);
        wr_beats(2, 1, 'h50);
        compared++;
        if (err_cnt !== 32'd1 || s_wr_cmd_ready !== 1'b1 || s_wr_data_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL early_last: err=%0d cmd_ready=%b data_ready=%b, required 1 1 0",
                     err_cnt, s_wr_cmd_ready, s_wr_data_ready);
        end
        wr_cmd(64'h200, 32'd64);
        wr_beats(1, 0, 'h60);
        compared++;
        if (wr_cmd_cnt !== 32'd4 || err_cnt !== 32'd1) begin
            mismatched++;
            $display("FAIL after_early_last: wr_cnt=%0d err=%0d, required 4 1", wr_cmd_cnt, err_cnt);
        end
        wr_cmd(64'h240, 32'd64);
        wr_beats(1, -1, 'h61);
        compared++;
        if (wr_cmd_cnt !== 32'd5 || err_cnt !== 32'd2 || s_wr_cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL missing_last: wr_cnt=%0d err=%0d cmd_ready=%b, required 5 2 1",
                     wr_cmd_cnt, err_cnt, s_wr_cmd_ready);
        end
    endtask

    task automatic test_len_errors();
        rd_cmd(64'h0, 32'd0);
        capture(0, 1'b0, 4);
        compared++;
        if (cap_extra != 0 || err_cnt !== 32'd3 || rd_cmd_cnt !== 32'd5 || s_rd_cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL rd_len_zero: beats=%0d err=%0d rd_cnt=%0d ready=%b, required 0 3 5 1",
                     cap_extra, err_cnt, rd_cmd_cnt, s_rd_cmd_ready);
        end
        rd_cmd(64'h0, 32'd2000);
        capture(16, 1'b0, 4);
        compared++;
        if (cap_n != 16 || cap_extra != 0 || err_cnt !== 32'd4) begin
            mismatched++;
            $display("FAIL clamp_count: beats=%0d+%0d err=%0d, required 16+0 4", cap_n, cap_extra, err_cnt);
        end
        compared++;
        if (cap_last[14] !== 1'b0 || cap_last[15] !== 1'b1 || cap_keep[15] !== '1 ||
            cap_data[0] !== 512'hA1 || cap_data[15] !== 512'hA0) begin
            mismatched++;
            $display("FAIL clamp_beats: last14=%b last15=%b keep15=%h d0=%0h d15=%0h, required 0 1 all-ones a1 a0",
                     cap_last[14], cap_last[15], cap_keep[15], cap_data[0], cap_data[15]);
        end
        @(negedge user_clk);
        s_rd_cmd_valid = 1'b1; s_rd_cmd_length = 32'd0;
        s_wr_cmd_valid = 1'b1; s_wr_cmd_length = 32'd0;
        compared++;
        if (s_rd_cmd_ready !== 1'b1 || s_wr_cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL dual_ready: rc=%b wc=%b, required 1 1", s_rd_cmd_ready, s_wr_cmd_ready);
        end
        @(negedge user_clk);
        s_rd_cmd_valid = 1'b0; s_wr_cmd_valid = 1'b0;
        compared++;
        if (err_cnt !== 32'd5 || rd_cmd_cnt !== 32'd7 || wr_cmd_cnt !== 32'd6) begin
            mismatched++;
            $display("FAIL dual_error: err=%0d rd=%0d wr=%0d, required 5 7 6", err_cnt, rd_cmd_cnt, wr_cmd_cnt);
        end
    endtask

    task automatic test_reset_mid_read();
        rd_cmd(64'h0, 32'd512);
        capture(2, 1'b0, 0);
        @(negedge user_clk);
        m_rd_data_ready = 1'b0; user_reset = 1'b1;
        @(negedge user_clk);
        compared++;
        if (m_rd_data_valid !== 1'b0 || rd_cmd_cnt !== 32'd0 || wr_cmd_cnt !== 32'd0 ||
            err_cnt !== 32'd0) begin
            mismatched++;
            $display("FAIL mid_reset: valid=%b rd=%0d wr=%0d err=%0d, required 0 0 0 0",
                     m_rd_data_valid, rd_cmd_cnt, wr_cmd_cnt, err_cnt);
        end
        user_reset = 1'b0;
        rd_cmd(64'h40, 32'd128);
        capture(2, 1'b0, 4);
        compared++;
        if (cap_n != 2 || cap_extra != 0 || cap_data[0] !== 512'd1 || cap_data[1] !== 512'd2 ||
            cap_last[1] !== 1'b1 || rd_cmd_cnt !== 32'd1) begin
            mismatched++;
            $display("FAIL post_reset_read: n=%0d+%0d d0=%0h d1=%0h last=%b rd=%0d, required 2+0 1 2 1 1",
                     cap_n, cap_extra, cap_data[0], cap_data[1], cap_last[1], rd_cmd_cnt);
        end
    endtask
`endif

    initial begin
        user_reset = 1'b1;
        s_rd_cmd_valid = 1'b0; s_rd_cmd_address = '0; s_rd_cmd_length = '0;
        s_wr_cmd_valid = 1'b0; s_wr_cmd_address = '0; s_wr_cmd_length = '0;
        m_rd_data_ready = 1'b0;
        s_wr_data_valid = 1'b0; s_wr_data_data = '0; s_wr_data_keep = '0; s_wr_data_last = 1'b0;
        test_reset();
`ifdef DMA_RESP_PATTERN_EN
        test_pattern();
`else
        test_write();
        test_read();
        test_read_partial();
        test_wrap();
        test_wr_errors();
        test_len_errors();
        test_reset_mid_read();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
